// File: rtl/menu_text_arb_if.sv
// menu_text_arb_if: requester/ROM bus bundle for menu_text_arb
//   req/req_xy   requester read requests and 8-bit addresses (8 bits per requester)
//   gnt          one-hot combinational grant
//   rom_xy       registered address to the text ROM
//   rom_code     ROM character code, one cycle after rom_xy
//   rsp_valid    one-hot response strobe back to the issuing requester
//   rsp_code     returned character code
//   busy         a read is in flight
interface menu_text_arb_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_xy;
    logic [NREQ-1:0]   gnt;
    logic [7:0]        rom_xy;
    logic [6:0]        rom_code;
    logic [NREQ-1:0]   rsp_valid;
    logic [6:0]        rsp_code;
    logic              busy;

    modport slave (
        input  req, req_xy, rom_code,
        output gnt, rom_xy, rsp_valid, rsp_code, busy
    );

    modport master (
        output req, req_xy, rom_code,
        input  gnt, rom_xy, rsp_valid, rsp_code, busy
    );
endinterface

// File: rtl/menu_text_arb.sv
// menu_text_arb: round-robin arbiter sharing one registered text ROM port among NREQ requesters
//   clk  system clock (shared with the ROM)
//   rst  asynchronous active-high reset
//   bus  menu_text_arb_if.slave: req/req_xy in, gnt out, rom_xy out, rom_code in,
//        rsp_valid/rsp_code out, busy out
// Define MENU_TEXT_ARB_PRIO_EN to give requester 0 fixed top priority; the other
// requesters then rotate among themselves only when requester 0 is idle.
module menu_text_arb #(
    parameter int NREQ = 2
) (
    input logic            clk,
    input logic            rst,
    menu_text_arb_if.slave bus
);
    if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
        $error("menu_text_arb: NREQ must be 2..4");
    end

    logic [1:0]      last;
    logic [1:0]      win;
    logic [1:0]      s1_tag;
    logic [1:0]      s2_tag;
    logic            s1_valid;
    logic            s2_valid;
    logic            xfer;
    logic            found;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] rsp_valid;
    logic [7:0]      rom_xy;
    logic [7:0]      xy_sel;
    int              idx;

`ifdef MENU_TEXT_ARB_PRIO_EN
    // Requester 0 always wins; 1..NREQ-1 rotate starting after last.
    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        if (bus.req[0]) begin
            gnt[0] = 1'b1;
            found  = 1'b1;
        end
        for (int k = 1; k < NREQ; k++) begin
            idx = 1 + ((int'(last) - 1 + k) % (NREQ - 1));
            if (!found && bus.req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                win      = 2'(idx);
            end
        end
    end
`else
    // Search starts one past the last winner and wraps modulo NREQ.
    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && bus.req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                win      = 2'(idx);
            end
        end
    end
`endif

    assign xfer = |(bus.req & gnt);

    always_comb begin
        xy_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) xy_sel = bus.req_xy[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_xy   <= 8'h00;
            s1_valid <= 1'b0;
            s1_tag   <= 2'd0;
            s2_valid <= 1'b0;
            s2_tag   <= 2'd0;
            last     <= 2'(NREQ - 1);
        end else begin
            s1_valid <= xfer;
            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
            if (xfer) begin
                rom_xy <= xy_sel;
                s1_tag <= win;
`ifdef MENU_TEXT_ARB_PRIO_EN
                // Grants to requester 0 must not disturb the rotation of the others.
                if (win != 2'd0) last <= win;
`else
                last <= win;
`endif
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = s2_valid && (s2_tag == 2'(i));
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rom_xy    = rom_xy;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_code  = bus.rom_code;
    assign bus.busy      = s1_valid | s2_valid;
endmodule

// File: tb/tb_menu_text_arb.sv
module tb_menu_text_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    menu_text_arb_if #(.NREQ(2)) if2 ();
    menu_text_arb_if #(.NREQ(3)) if3 ();
    menu_text_arb_if #(.NREQ(4)) if4 ();

    menu_text_arb #(.NREQ(2)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
    menu_text_arb #(.NREQ(3)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));
    menu_text_arb #(.NREQ(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

    always @(posedge clk) begin
        if2.rom_code <= if2.rom_xy[6:0] ^ 7'h55;
        if3.rom_code <= if3.rom_xy[6:0] ^ 7'h55;
        if4.rom_code <= if4.rom_xy[6:0] ^ 7'h55;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Three-requester expected grant for cycle k of the u3 scenario.
    function automatic logic [2:0] g3(input int k);
`ifdef MENU_TEXT_ARB_PRIO_EN
        if (k < 4) return 3'b001;
        if (k < 8) return (k % 2 == 0) ? 3'b010 : 3'b100;
        return 3'b000;
`else
        if (k < 6) return 3'b001 << (k % 3);
        return 3'b000;
`endif
    endfunction

    // u3 requesters use addresses 0x10, 0x20, 0x30.
    function automatic logic [6:0] c3(input logic [2:0] g);
        return g == 3'b001 ? 7'h45 : g == 3'b010 ? 7'h75 : 7'h65;
    endfunction

    initial begin
        if2.req = '0; if2.req_xy = '0;
        if3.req = '0; if3.req_xy = '0;
        if4.req = '0; if4.req_xy = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_rom_xy", if2.rom_xy, 8'h00);
        check("reset_rsp", if2.rsp_valid, 2'b00);
        check("reset_busy", if2.busy, 1'b0);
        check("reset_gnt", if2.gnt, 2'b00);
        check("reset_rom_xy4", if4.rom_xy, 8'h00);
        check("reset_busy4", if4.busy, 1'b0);
        tick();

        // Single read from requester 1
        if2.req = 2'b10; if2.req_xy = 16'h4100;
        #1;
        check("single_gnt", if2.gnt, 2'b10);
        tick();
        if2.req = 2'b00;
        #1;
        check("single_rom_xy", if2.rom_xy, 8'h41);
        check("single_rsp_early", if2.rsp_valid, 2'b00);
        check("single_busy", if2.busy, 1'b1);
        tick();
        #1;
        check("single_rsp", if2.rsp_valid, 2'b10);
        check("single_code", if2.rsp_code, 7'h14);
        tick();

        // Contention, NREQ=2: addresses 0x10 (req 0) and 0x20 (req 1)
        if2.req_xy = 16'h2010;
        for (int k = 0; k < 8; k++) begin
            if2.req = (k < 6) ? 2'b11 : 2'b00;
            #1;
            check("cont_gnt", if2.gnt, (k < 6) ? ((k % 2) ? 2'b10 : 2'b01) : 2'b00);
            if (k >= 2) begin
                check("cont_rsp", if2.rsp_valid, ((k - 2) % 2) ? 2'b10 : 2'b01);
                check("cont_code", if2.rsp_code, ((k - 2) % 2) ? 7'h75 : 7'h45);
            end else begin
                check("cont_rsp_none", if2.rsp_valid, 2'b00);
            end
            tick();
        end

        // Idle: nothing moves, rom_xy keeps the last address (0x20)
        if2.req = '0;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("idle_gnt", if2.gnt, 2'b00);
            check("idle_rsp", if2.rsp_valid, 2'b00);
            check("idle_busy", if2.busy, 1'b0);
            check("idle_rom_xy", if2.rom_xy, 8'h20);
            check("idle_gnt4", if4.gnt, 4'b0000);
            tick();
        end

        // Streaming, NREQ=4: requester 2 issues 0x00..0x0F back to back
        for (int k = 0; k < 18; k++) begin
            if4.req = (k < 16) ? 4'b0100 : 4'b0000;
            if4.req_xy = {8'h00, 8'(k), 16'h0000};
            #1;
            check("stream_gnt", if4.gnt, (k < 16) ? 4'b0100 : 4'b0000);
            if (k >= 1) check("stream_busy", if4.busy, 1'b1);
            if (k >= 1 && k <= 16) check("stream_rom_xy", if4.rom_xy, 8'(k - 1));
            if (k >= 2) begin
                check("stream_rsp", if4.rsp_valid, 4'b0100);
                check("stream_code", if4.rsp_code, 7'(k - 2) ^ 7'h55);
            end else begin
                check("stream_rsp_none", if4.rsp_valid, 4'b0000);
            end
            tick();
        end
        #1;
        check("stream_busy_end", if4.busy, 1'b0);
        check("stream_rsp_end", if4.rsp_valid, 4'b0000);
        tick();

        // Reset one cycle after a transfer
        if4.req = 4'b0010; if4.req_xy = 32'h0000_3300;
        #1;
        check("rst_gnt", if4.gnt, 4'b0010);
        tick();
        if4.req = 4'b0000;
        #1;
        check("rst_pre_rom_xy", if4.rom_xy, 8'h33);
        check("rst_pre_busy", if4.busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_rom_xy", if4.rom_xy, 8'h00);
        check("rst_busy", if4.busy, 1'b0);
        check("rst_rsp", if4.rsp_valid, 4'b0000);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("post_rst_rsp", if4.rsp_valid, 4'b0000);
            check("post_rst_busy", if4.busy, 1'b0);
            tick();
        end

        // NREQ=3, all requesting (rotation, or fixed priority for requester 0)
        if3.req_xy = 24'h302010;
        for (int k = 0; k < 10; k++) begin
`ifdef MENU_TEXT_ARB_PRIO_EN
            if3.req = (k < 4) ? 3'b111 : (k < 8) ? 3'b110 : 3'b000;
`else
            if3.req = (k < 6) ? 3'b111 : 3'b000;
`endif
            #1;
            check("nreq3_gnt", if3.gnt, g3(k));
            if (k >= 2 && g3(k - 2) != 3'b000) begin
                check("nreq3_rsp", if3.rsp_valid, g3(k - 2));
                check("nreq3_code", if3.rsp_code, c3(g3(k - 2)));
            end else begin
                check("nreq3_rsp_none", if3.rsp_valid, 3'b000);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/menu_text_arb.md
# menu_text_arb

Round-robin arbiter that shares one registered menu text ROM port (8-bit `char_xy` in, 7-bit `char_code` out one clock later) between up to four character-rendering requesters. It sits between the per-screen text renderers and the single text ROM instance. It tracks the ROM's one-cycle read latency and routes each returned character code back to the requester that issued the address.

## Interface

Parameters:
- `NREQ`, default 2: number of requesters, legal range 2..4.

Ports:
- `clk`  in  1  system clock; the ROM shares this clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  per-requester read request. Level; held until granted.
- `req_xy`  in  8*NREQ  per-requester ROM address. Requester i occupies bits `[8*i+7:8*i]`; stable while `req[i]` is high.
- `gnt`  out  NREQ  one-hot grant, combinational, same cycle as the accepted request.
- `rom_xy`  out  8  registered address to the ROM `char_xy` input.
- `rom_code`  in  7  ROM `char_code` output, valid one cycle after `rom_xy`.
- `rsp_valid`  out  NREQ  one-hot response strobe.
- `rsp_code`  out  7  returned character code, valid while any `rsp_valid` bit is high.
- `busy`  out  1  high while any read is in flight (stage 1 or stage 2 valid).

## Operation

- A transfer happens on the clock edge where `req[i] & gnt[i]` is high. At most one `gnt` bit is set per cycle, and `gnt` is all-zero when no requests are pending.
- Round-robin winner search starts at `last+1` (mod NREQ) and takes the first index with `req` high. The `last` pointer is updated only on a transfer.
- Pipeline:
  - Stage 1 registers `rom_xy`, `s1_valid` and `s1_tag` (winner index) on the transfer edge.
  - Stage 2 registers `s2_valid` and `s2_tag` from stage 1 on the next edge.
  - `rsp_valid = s2_valid ? onehot(s2_tag) : 0`.
  - `rsp_code = rom_code`, passed through combinationally.
- Back-to-back transfers are allowed every cycle; there is no backpressure on responses. A requester must take `rsp_code` in the cycle its `rsp_valid` bit is high.
- Requester i may change `req_xy[i]` in the cycle after its `gnt[i]`, so it can stream consecutive addresses.
- `rom_xy` holds its last value when no transfer occurs.
- Requester indices at or above NREQ never exist. `tag` width is 2 bits.

## Timing

- Latency: transfer edge T → `rom_xy` valid in cycle T+1 → `rsp_valid`/`rsp_code` in cycle T+2. Total 2 cycles.
- Throughput: 1 read per cycle aggregate. Each of the K active requesters gets 1 grant per K cycles.
- Reset values (asynchronous): `rom_xy` = 8'h00, `s1_valid` = `s2_valid` = 0, tags = 0, `last` = NREQ-1 so requester 0 wins first. Resulting outputs: `rsp_valid` = 0, `busy` = 0.
- Reset mid-operation: in-flight reads are discarded. No `rsp_valid` is issued for them after `rst` deasserts.
- Simultaneous requests: resolved strictly by the rotation above. A requester that drops `req` before being granted loses its slot without side effects.
- `gnt` depends only on `req` and registered `last`; there is no combinational path from `rom_code`.

## Configuration

- `MENU_TEXT_ARB_PRIO_EN` defined: requester 0 has fixed top priority and is granted whenever `req[0]` is high. Requesters 1..NREQ-1 round-robin among themselves only in cycles with `req[0]` low. `last` then tracks only indices 1..NREQ-1.
- Not defined: pure round-robin over all NREQ requesters as above.

## Test plan

Bench ROM model: registered, `char_code = req_xy[6:0] ^ 7'h55`.

- Single read: reset, then `req[1]`=1 with `req_xy[1]`=8'h41 for one cycle. Required: `gnt`=2'b10 in that cycle; `rom_xy`=8'h41 next cycle; two cycles after the grant, `rsp_valid`=2'b10 and `rsp_code`=7'h14.
- Contention, NREQ=2: both requesters hold `req` for 6 cycles. Required: grants alternate 0,1,0,1,0,1 starting at 0, with responses in the same order 2 cycles later.
- Streaming, NREQ=4: requester 2 alone issues addresses 8'h00..8'h0F on consecutive cycles. Required: 16 consecutive `rsp_valid`=4'b0100 with codes `0x55^k`, and `busy` high throughout.
- Reset mid-flight: assert `rst` one cycle after a transfer. Required: no `rsp_valid` at any time afterward until a new request is made, and `rom_xy`=8'h00 immediately on reset.
- Idle: `req`=0 for 10 cycles. Required: `gnt`=0, `rsp_valid`=0, `busy`=0, and `rom_xy` unchanged.
- With `MENU_TEXT_ARB_PRIO_EN` defined, NREQ=3, all requesting: requester 0 is granted every cycle. Drop `req[0]`: grants then alternate 1,2,1,2.
